operand_fetch_unit: RTL and testbench

- Read-side companion to the register file in the multicycle CPU.
- Accepts a decoded instruction word and drives the register file's rs/rt read addresses.
- Captures the returned operands into A/B holding registers and presents them to the execute stage with a valid/ready handshake.
- Resolves the read-during-write case against the same-cycle write-back port, so the execute stage never sees a stale operand.

---
 rtl/operand_fetch_unit_pkg.sv | 27 ++
 rtl/ofu_bypass_mux.sv | 27 ++
 rtl/operand_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_operand_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_unit_pkg.sv
// Shared CPU definitions for the operand fetch unit: datapath widths,
// instruction field positions, the hard-wired zero register and FSM states.
package operand_fetch_unit_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;
    localparam int INSTR_W    = 32;

    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    localparam logic [CPU_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } ofu_state_e;

endpackage

// File: rtl/ofu_bypass_mux.sv
// Per-operand source select: register 0 reads as zero, a matching same-cycle
// write-back wins over the base value, otherwise the base value passes through.
module ofu_bypass_mux
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    // Zero register dominates, then bypass, then the base value
    always_comb begin
        data = rf_data;
        if (addr == ADDR_W'(ZERO_REG)) begin
            data = '0;
        end else if (wb_en && (wb_addr == addr)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: latches a decoded instruction, reads rs/rt from the
// register file, captures operands with write-back bypass and presents them
// to execute under a valid/ready handshake.
// Build option OFU_FWD_EN: when defined, same-cycle write-backs are forwarded
// in READ and snooped in HOLD; when undefined, a conflicting write-back in
// READ stalls one cycle and the operands are re-read after it commits.
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic [ADDR_W-1:0] rf_rs_addr,
    output logic [ADDR_W-1:0] rf_rt_addr,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] imm_ext,
    output logic [ADDR_W-1:0] rt_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o
);

    ofu_state_e                 state;
    logic [INSTR_W-1:0]         instr_q;
    logic [ADDR_W-1:0]          rs;
    logic [ADDR_W-1:0]          rt;
    logic [ADDR_W-1:0]          rd;
    logic signed [IMM_W-1:0]    imm;
    logic                       fwd_en;
    logic [DATA_W-1:0]          fwd_data;
    logic                       stall;
    logic [DATA_W-1:0]          base_a;
    logic [DATA_W-1:0]          base_b;
    logic [DATA_W-1:0]          sel_a;
    logic [DATA_W-1:0]          sel_b;

    function automatic logic [DATA_W-1:0] sign_ext_imm(input logic signed [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    assign rs  = ADDR_W'(instr_q[RS_HI:RS_LO]);
    assign rt  = ADDR_W'(instr_q[RT_HI:RT_LO]);
    assign rd  = ADDR_W'(instr_q[RD_HI:RD_LO]);
    assign imm = instr_q[IMM_HI:IMM_LO];

    assign rf_rs_addr = rs;
    assign rf_rt_addr = rt;

`ifdef OFU_FWD_EN
    assign fwd_en   = wb_en;
    assign fwd_data = wb_data;
    assign stall    = 1'b0;
`else
    // Without a bypass path, a write landing on a source register this cycle
    // means the register file still shows the old value: wait for the commit.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign fwd_en   = 1'b0;
    assign fwd_data = '0;
    assign stall    = wb_en &&
                      (((wb_addr == rs) && (rs != ADDR_W'(ZERO_REG))) ||
                       ((wb_addr == rt) && (rt != ADDR_W'(ZERO_REG))));
`endif

    // In HOLD the base value is the held operand, so the same mux doubles as
    // the write-back snoop; in READ it is the fresh register file data.
    assign base_a = (state == HOLD) ? op_a : rf_rs_data;
    assign base_b = (state == HOLD) ? op_b : rf_rt_data;

    ofu_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_a (
        .addr    (rs),
        .rf_data (base_a),
        .wb_en   (fwd_en),
        .wb_addr (wb_addr),
        .wb_data (fwd_data),
        .data    (sel_a)
    );

    ofu_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_b (
        .addr    (rt),
        .rf_data (base_b),
        .wb_en   (fwd_en),
        .wb_addr (wb_addr),
        .wb_data (fwd_data),
        .data    (sel_b)
    );

    // Fetch FSM with registered handshake outputs and operand holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            instr_q   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            imm_ext   <= '0;
            rt_addr_o <= '0;
            rd_addr_o <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        instr_q  <= instr;
                        in_ready <= 1'b0;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (!stall) begin
                        op_a      <= sel_a;
                        op_b      <= sel_b;
                        imm_ext   <= sign_ext_imm(imm);
                        rt_addr_o <= rt;
                        rd_addr_o <= rd;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    op_a <= sel_a;
                    op_b <= sel_b;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a small register file model.
// Expected latency and snoop behaviour follow the OFU_FWD_EN build option.
module tb_operand_fetch_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [4:0]  rf_rs_addr;
    logic [4:0]  rf_rt_addr;
    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm_ext;
    logic [4:0]  rt_addr_o;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];

    operand_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rf_rs_addr (rf_rs_addr),
        .rf_rt_addr (rf_rt_addr),
        .rf_rs_data (rf_rs_data),
        .rf_rt_data (rf_rt_data),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .imm_ext    (imm_ext),
        .rt_addr_o  (rt_addr_o),
        .rd_addr_o  (rd_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, write on the rising edge
    assign rf_rs_data = rf[rf_rs_addr];
    assign rf_rt_data = rf[rf_rt_addr];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
            rf[2] <= 32'h0000_1111;
            rf[3] <= 32'h0000_3333;
            rf[4] <= 32'h1111_0000;
            rf[5] <= 32'h0000_0000;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    task automatic issue(input logic [31:0] w);
        in_valid = 1'b1;
        instr    = w;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'h0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_op_a",      op_a,               32'h0);
        chk("rst_rs_addr",   {27'd0, rf_rs_addr}, 32'd0);

        // Plain read: rs=2, rt=4, imm=FFF0 (rd field = 31)
        issue(mk(5'd2, 5'd4, 16'hFFF0));
        chk("plain_read_in_ready",  {31'd0, in_ready},  32'd0);
        chk("plain_read_not_valid", {31'd0, out_valid}, 32'd0);
        chk("plain_rs_addr",        {27'd0, rf_rs_addr}, 32'd2);
        chk("plain_rt_addr",        {27'd0, rf_rt_addr}, 32'd4);
        tick();
        chk("plain_out_valid", {31'd0, out_valid}, 32'd1);
        chk("plain_op_a",      op_a,    32'h0000_1111);
        chk("plain_op_b",      op_b,    32'h1111_0000);
        chk("plain_imm_ext",   imm_ext, 32'hFFFF_FFF0);
        chk("plain_rt_o",      {27'd0, rt_addr_o}, 32'd4);
        chk("plain_rd_o",      {27'd0, rd_addr_o}, 32'd31);
        // in_valid while busy must be ignored
        in_valid = 1'b1;
        instr    = mk(5'd3, 5'd3, 16'h0001);
        tick();
        in_valid = 1'b0;
        chk("busy_ignore_rs_addr", {27'd0, rf_rs_addr}, 32'd2);
        chk("busy_hold_op_a",      op_a, 32'h0000_1111);
        chk("busy_hold_valid",     {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("plain_handoff_valid", {31'd0, out_valid}, 32'd0);
        chk("plain_handoff_ready", {31'd0, in_ready},  32'd1);

        // Forward in READ: rs=5, write r5 while reading
        issue(mk(5'd5, 5'd0, 16'h0004));
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0;
`ifndef OFU_FWD_EN
        chk("fwd_stall_not_valid", {31'd0, out_valid}, 32'd0);
        tick();
`endif
        chk("fwd_out_valid", {31'd0, out_valid}, 32'd1);
        chk("fwd_op_a",      op_a, 32'hDEAD_BEEF);
        chk("fwd_op_b_zero", op_b, 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fwd_handoff_valid", {31'd0, out_valid}, 32'd0);

        // Zero register: write to r0 must not forward and must not stall
        issue(mk(5'd0, 5'd0, 16'h8000));
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'h1234_5678;
        tick();
        wb_en = 1'b0;
        chk("zero_out_valid", {31'd0, out_valid}, 32'd1);
        chk("zero_op_a",      op_a, 32'h0);
        chk("zero_op_b",      op_b, 32'h0);
        chk("zero_imm_ext",   imm_ext, 32'hFFFF_8000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure with snoop on rt=4 during the second HOLD cycle
        issue(mk(5'd2, 5'd4, 16'h7FFF));
        tick();
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_op_b_initial", op_b, 32'h1111_0000);
        chk("bp_imm_ext", imm_ext, 32'h0000_7FFF);
        wb_en   = 1'b1;
        wb_addr = 5'd4;
        wb_data = 32'hA5A5_A5A5;
        tick();
        wb_en = 1'b0;
`ifdef OFU_FWD_EN
        chk("bp_op_b_snoop", op_b, 32'hA5A5_A5A5);
`else
        chk("bp_op_b_nosnoop", op_b, 32'h1111_0000);
`endif
        chk("bp_op_a_stable", op_a, 32'h0000_1111);
        tick();
        tick();
`ifdef OFU_FWD_EN
        chk("bp_op_b_stable", op_b, 32'hA5A5_A5A5);
`else
        chk("bp_op_b_stable", op_b, 32'h1111_0000);
`endif
        chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_ready", {31'd0, in_ready},  32'd1);

        // rs == rt = 3 with a write to r3 during READ
        issue(mk(5'd3, 5'd3, 16'h0000));
        wb_en   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'hCAFE_F00D;
        tick();
        wb_en = 1'b0;
`ifndef OFU_FWD_EN
        chk("same_stall_not_valid", {31'd0, out_valid}, 32'd0);
        tick();
`endif
        chk("same_out_valid", {31'd0, out_valid}, 32'd1);
        chk("same_op_a", op_a, 32'hCAFE_F00D);
        chk("same_op_b", op_b, 32'hCAFE_F00D);

        // Reset mid-HOLD
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_op_a",      op_a, 32'h0);
        chk("midrst_op_b",      op_b, 32'h0);
        chk("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("midrst_rs_addr",   {27'd0, rf_rs_addr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
